misc_alu_sched: RTL and testbench

- Shares one 8-bit add/sub/mul/compare-select datapath (A uint8, B uint4 zero-extended) among NREQ requesters.
- Round-robin arbitration, one operation in flight, valid/ready handshakes on both the request and response sides.
- Sits between requester engines and the shared arithmetic resource; sequences multi-cycle multiply.

---
 rtl/misc_alu_sched.sv | 123 ++++++++++++
 tb/tb_misc_alu_sched.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/misc_alu_sched.sv
// misc_alu_sched: round-robin arbiter sharing one add/sub/mul/compare-select ALU among NREQ requesters
// Ports: CLK/RST_N (sync active-low); REQ_VALID/REQ_READY/REQ_OP/REQ_A/REQ_B per-requester request
// channel (slice i of each bus belongs to requester i); RSP_VALID/RSP_READY/RSP_ID/RSP_DATA/RSP_GT
// single response channel. Define MISC_ALU_SCHED_PRIO_EN to give requester 0 absolute priority.
module misc_alu_sched #(
  parameter int NREQ       = 4,
  parameter int AW         = 8,
  parameter int BW         = 4,
  parameter int MUL_CYCLES = 2
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic [NREQ-1:0]          REQ_VALID,
  output logic [NREQ-1:0]          REQ_READY,
  input  logic [2*NREQ-1:0]        REQ_OP,
  input  logic [AW*NREQ-1:0]       REQ_A,
  input  logic [BW*NREQ-1:0]       REQ_B,
  output logic                     RSP_VALID,
  input  logic                     RSP_READY,
  output logic [$clog2(NREQ)-1:0]  RSP_ID,
  output logic [AW-1:0]            RSP_DATA,
  output logic                     RSP_GT
);
  localparam int IW = $clog2(NREQ);
  localparam int CW = MUL_CYCLES > 1 ? $clog2(MUL_CYCLES) : 1;
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t state;
  logic [IW-1:0] ptr, win, idx, nxt_ptr, id;
  logic [IW:0] s;
  logic found;
  logic [1:0] op_w, op;
  logic [AW-1:0] a_w, a, bz, sum, dif, prd, res;
  logic [BW-1:0] b_w, b;
  logic [CW-1:0] cnt;
  logic gt;
  // Search upward from ptr with wrap at NREQ-1, so non-power-of-two NREQ never aliases.
  always_comb begin
    found = 1'b0;
    win = '0;
    s = '0;
    idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      s = {1'b0, ptr} + (IW+1)'(k);
      idx = IW'(s >= (IW+1)'(NREQ) ? s - (IW+1)'(NREQ) : s);
      if (!found && REQ_VALID[idx]) begin
        found = 1'b1;
        win = idx;
      end
    end
`ifdef MISC_ALU_SCHED_PRIO_EN
    if (REQ_VALID[0]) begin
      found = 1'b1;
      win = '0;
    end
`endif
    op_w = '0;
    a_w = '0;
    b_w = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (win == IW'(k)) begin
        op_w = REQ_OP[2*k +: 2];
        a_w = REQ_A[AW*k +: AW];
        b_w = REQ_B[BW*k +: BW];
      end
    end
    REQ_READY = '0;
    REQ_READY[win] = RST_N && state == IDLE && found;
    nxt_ptr = win == IW'(NREQ-1) ? '0 : win + 1'b1;
  end
  always_comb begin
    bz = AW'(b);
    gt = a > bz;
    sum = a + bz;
    dif = a - bz;
    prd = a * bz;
    res = op == 2'd0 ? sum : op == 2'd1 ? dif : op == 2'd2 ? prd : gt ? sum : dif;
  end
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state <= IDLE;
      ptr <= '0;
      id <= '0;
      op <= '0;
      a <= '0;
      b <= '0;
      cnt <= '0;
      RSP_VALID <= 1'b0;
      RSP_ID <= '0;
      RSP_DATA <= '0;
      RSP_GT <= 1'b0;
    end else begin
      case (state)
        IDLE: if (found) begin
          id <= win;
          op <= op_w;
          a <= a_w;
          b <= b_w;
          cnt <= op_w == 2'd2 ? CW'(MUL_CYCLES-1) : '0;
`ifdef MISC_ALU_SCHED_PRIO_EN
          ptr <= win == '0 ? ptr : nxt_ptr;
`else
          ptr <= nxt_ptr;
`endif
          state <= EXEC;
        end
        EXEC: if (cnt == '0) begin
          RSP_DATA <= res;
          RSP_GT <= gt;
          RSP_ID <= id;
          RSP_VALID <= 1'b1;
          state <= RESP;
        end else begin
          cnt <= cnt - 1'b1;
        end
        RESP: if (RSP_READY) begin
          RSP_VALID <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_misc_alu_sched.sv
// tb_misc_alu_sched: scoreboard bench for misc_alu_sched (NREQ=4, AW=8, BW=4, MUL_CYCLES=2)
module tb_misc_alu_sched;
  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  logic [3:0] REQ_VALID = '0;
  logic [3:0] REQ_READY;
  logic [7:0] REQ_OP = '0;
  logic [31:0] REQ_A = '0;
  logic [15:0] REQ_B = '0;
  logic RSP_VALID;
  logic RSP_READY = 1'b1;
  logic [1:0] RSP_ID;
  logic [7:0] RSP_DATA;
  logic RSP_GT;
  int total = 0;
  int bad = 0;
  int cyc = 0;
  typedef struct {int id; int data; int gt;} exp_t;
  exp_t sb[$];
  misc_alu_sched #(.NREQ(4), .AW(8), .BW(4), .MUL_CYCLES(2)) dut (
    .CLK(CLK), .RST_N(RST_N), .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_OP(REQ_OP),
    .REQ_A(REQ_A), .REQ_B(REQ_B), .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_ID(RSP_ID),
    .RSP_DATA(RSP_DATA), .RSP_GT(RSP_GT)
  );
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc++;
  function automatic int model(int op, int a, int b);
    int s = (a + b) % 256;
    int d = (a - b + 256) % 256;
    int p = (a * b) % 256;
    return op == 0 ? s : op == 1 ? d : op == 2 ? p : (a > b ? s : d);
  endfunction
  // Drives one request from a negedge until granted; hs is the cycle count in the handshake cycle.
  task automatic issue(input int id, input int op, input int a, input int b, input bit push, output int hs);
    bit ok = 0;
    hs = -1;
    REQ_VALID[id] = 1'b1;
    REQ_OP[2*id +: 2] = 2'(op);
    REQ_A[8*id +: 8] = 8'(a);
    REQ_B[4*id +: 4] = 4'(b);
    for (int t = 0; t < 50 && !ok; t++) begin
      #1;
      if (REQ_READY[id]) begin
        ok = 1;
        hs = cyc;
        if (push) sb.push_back('{id, model(op, a, b), int'(a > b)});
      end
      @(negedge CLK);
    end
    REQ_VALID[id] = 1'b0;
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL grant_req%0d: REQ_READY=%b never granted, required a grant", id, REQ_READY);
    end
  endtask
  task automatic collect(output logic [1:0] i, output logic [7:0] d, output logic g, output int c, output bit ok);
    ok = 0;
    i = 'x;
    d = 'x;
    g = 'x;
    c = -1;
    for (int t = 0; t < 50 && !ok; t++) begin
      if (RSP_VALID) begin
        ok = 1;
        i = RSP_ID;
        d = RSP_DATA;
        g = RSP_GT;
        c = cyc;
      end else @(negedge CLK);
    end
  endtask
  task automatic test_reset();
    RST_N = 1'b0;
    REQ_VALID = '1;
    repeat (3) @(negedge CLK);
    #1;
    total++; if (REQ_READY !== 4'b0) begin bad++; $display("FAIL reset_ready: got %b want 0000", REQ_READY); end
    total++; if (RSP_VALID !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", RSP_VALID); end
    total++; if (RSP_DATA !== 8'h00) begin bad++; $display("FAIL reset_data: got %h want 00", RSP_DATA); end
    total++; if (RSP_ID !== 2'd0) begin bad++; $display("FAIL reset_id: got %0d want 0", RSP_ID); end
    total++; if (RSP_GT !== 1'b0) begin bad++; $display("FAIL reset_gt: got %b want 0", RSP_GT); end
    REQ_VALID = '0;
    RST_N = 1'b1;
    @(negedge CLK);
  endtask
  task automatic test_arith();
    int tid[6] = '{1, 0, 2, 3, 0, 1};
    int top[6] = '{0, 1, 3, 3, 2, 2};
    int ta[6]  = '{254, 3, 5, 127, 20, 255};
    int tb_[6] = '{3, 5, 9, 2, 15, 15};
    int tl[6]  = '{2, 2, 2, 2, 3, 3};
    int hs, c;
    logic [1:0] i;
    logic [7:0] d;
    logic g;
    bit ok;
    exp_t e;
    RSP_READY = 1'b1;
    for (int n = 0; n < 6; n++) begin
      issue(tid[n], top[n], ta[n], tb_[n], 1, hs);
      REQ_A = '1;
      REQ_B = '1;
      collect(i, d, g, c, ok);
      e = sb.size() > 0 ? sb.pop_front() : '{-1, -1, -1};
      total++;
      if (!ok) begin
        bad++;
        $display("FAIL arith%0d_timeout: RSP_VALID=%b, required 1", n, RSP_VALID);
      end else begin
        if (d !== 8'(e.data)) begin bad++; $display("FAIL arith%0d_data: got %h want %h", n, d, e.data); end
        total++; if (i !== 2'(e.id)) begin bad++; $display("FAIL arith%0d_id: got %0d want %0d", n, i, e.id); end
        total++; if (g !== 1'(e.gt)) begin bad++; $display("FAIL arith%0d_gt: got %b want %0d", n, g, e.gt); end
        total++; if (c - hs != tl[n]) begin bad++; $display("FAIL arith%0d_latency: got %0d want %0d", n, c - hs, tl[n]); end
      end
      @(negedge CLK);
      total++; if (RSP_VALID !== 1'b0) begin bad++; $display("FAIL arith%0d_drop: RSP_VALID=%b want 0", n, RSP_VALID); end
    end
  endtask
  task automatic test_reset_mid_mul();
    int hs;
    bit seen = 0;
    issue(0, 2, 10, 3, 0, hs);
    RST_N = 1'b0;
    REQ_VALID[1] = 1'b1;
    @(negedge CLK);
    #1;
    total++; if (RSP_VALID !== 1'b0) begin bad++; $display("FAIL midrst_valid: got %b want 0", RSP_VALID); end
    total++; if (REQ_READY !== 4'b0) begin bad++; $display("FAIL midrst_ready: got %b want 0000", REQ_READY); end
    REQ_VALID = '0;
    RST_N = 1'b1;
    for (int t = 0; t < 10; t++) begin
      @(negedge CLK);
      if (RSP_VALID) seen = 1;
    end
    total++; if (seen) begin bad++; $display("FAIL midrst_ghost: response seen=%b want 0", seen); end
  endtask
  task automatic test_backpressure();
    int hs, c;
    logic [1:0] i;
    logic [7:0] d;
    logic g;
    bit ok;
    exp_t e;
    RSP_READY = 1'b0;
    issue(2, 0, 50, 7, 1, hs);
    collect(i, d, g, c, ok);
    e = sb.size() > 0 ? sb.pop_front() : '{-1, -1, -1};
    total++; if (!ok || d !== 8'(e.data) || i !== 2'(e.id)) begin bad++; $display("FAIL bp_first: ok=%0d id=%0d data=%h want id=%0d data=%h", ok, i, d, e.id, e.data); end
    REQ_VALID[3] = 1'b1;
    REQ_OP[7:6] = 2'd1;
    REQ_A[31:24] = 8'd9;
    REQ_B[15:12] = 4'd4;
    sb.push_back('{3, model(1, 9, 4), 1});
    for (int t = 0; t < 5; t++) begin
      @(negedge CLK);
      #1;
      total++;
      if ({RSP_VALID, RSP_ID, RSP_DATA, REQ_READY} !== {1'b1, 2'd2, 8'd57, 4'b0000}) begin
        bad++;
        $display("FAIL bp_hold%0d: valid=%b id=%0d data=%0d ready=%b want 1/2/57/0000", t, RSP_VALID, RSP_ID, RSP_DATA, REQ_READY);
      end
    end
    RSP_READY = 1'b1;
    @(negedge CLK);
    #1;
    total++; if (REQ_READY !== 4'b1000) begin bad++; $display("FAIL bp_regrant: got %b want 1000", REQ_READY); end
    total++; if (RSP_VALID !== 1'b0) begin bad++; $display("FAIL bp_release: RSP_VALID=%b want 0", RSP_VALID); end
    @(negedge CLK);
    REQ_VALID[3] = 1'b0;
    collect(i, d, g, c, ok);
    e = sb.size() > 0 ? sb.pop_front() : '{-1, -1, -1};
    total++; if (!ok || d !== 8'(e.data) || i !== 2'(e.id) || g !== 1'(e.gt)) begin bad++; $display("FAIL bp_second: ok=%0d id=%0d data=%h gt=%b want id=%0d data=%h gt=%0d", ok, i, d, g, e.id, e.data, e.gt); end
    @(negedge CLK);
  endtask
  task automatic test_round_robin();
    int order[5];
    int c, prev;
    logic [1:0] i;
    logic [7:0] d;
    logic g;
    bit ok;
    exp_t e;
`ifdef MISC_ALU_SCHED_PRIO_EN
    order = '{0, 0, 0, 0, 0};
`else
    order = '{0, 1, 2, 3, 0};
`endif
    RST_N = 1'b0;
    repeat (2) @(negedge CLK);
    for (int r = 0; r < 4; r++) begin
      REQ_OP[2*r +: 2] = 2'd0;
      REQ_A[8*r +: 8] = 8'(16*r + 1);
      REQ_B[4*r +: 4] = 4'(r + 1);
    end
    for (int k = 0; k < 5; k++) sb.push_back('{order[k], model(0, 16*order[k] + 1, order[k] + 1), 1});
    RSP_READY = 1'b1;
    REQ_VALID = '1;
    RST_N = 1'b1;
    prev = -1;
    for (int k = 0; k < 5; k++) begin
      collect(i, d, g, c, ok);
      e = sb.size() > 0 ? sb.pop_front() : '{-1, -1, -1};
      total++; if (!ok || i !== 2'(e.id)) begin bad++; $display("FAIL rr%0d_id: ok=%0d got %0d want %0d", k, ok, i, e.id); end
      total++; if (d !== 8'(e.data)) begin bad++; $display("FAIL rr%0d_data: got %h want %h", k, d, e.data); end
      if (k > 0) begin
        total++; if (c - prev != 3) begin bad++; $display("FAIL rr%0d_period: got %0d want 3", k, c - prev); end
      end
      prev = c;
      @(negedge CLK);
    end
    REQ_VALID = '0;
  endtask
  initial begin
    test_reset();
    test_arith();
    test_reset_mid_mul();
    test_backpressure();
    test_round_robin();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
    $fatal(1, "watchdog");
  end
endmodule
